// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit multiplexed 7-segment scanner with blanking and frame-synchronous double-buffered value.
module display_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        busy,
  output logic        frame_done
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_q, pend_d, shadow_q, shadow_d;
  logic          busy_q, busy_d, fd_q, fd_d, dp_n_q, dp_n_d;
  logic [3:0]    an_n_q, an_n_d, nib;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          slot_end, boundary, an_on;

  assign slot_end = en && cnt_q == LAST;
  assign boundary = slot_end && idx_q == 2'd3;
  assign an_on    = en && cnt_q >= BLK && digit_en[idx_q];
  assign nib      = shadow_q[{idx_q, 2'b00} +: 4];

  // Shadow only moves on the frame boundary so a frame never tears; a load on that very edge bypasses pending.
  always_comb begin
    cnt_d    = !en ? cnt_q : slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q + {1'b0, slot_end};
    pend_d   = load ? value : pend_q;
    busy_d   = boundary ? 1'b0 : (load | busy_q);
    shadow_d = !boundary ? shadow_q : load ? value : busy_q ? pend_q : shadow_q;
    fd_d     = boundary;
    an_n_d   = an_on ? ~(4'b0001 << idx_q) : 4'hF;
    dp_n_d   = ~(an_on & dp_en[idx_q]);
  end

  always_comb begin
    seg_n_d = 7'h7F;
    case (nib)
      4'h0: seg_n_d = 7'h40;
      4'h1: seg_n_d = 7'h79;
      4'h2: seg_n_d = 7'h24;
      4'h3: seg_n_d = 7'h30;
      4'h4: seg_n_d = 7'h19;
      4'h5: seg_n_d = 7'h12;
      4'h6: seg_n_d = 7'h02;
      4'h7: seg_n_d = 7'h78;
      4'h8: seg_n_d = 7'h00;
      4'h9: seg_n_d = 7'h10;
      4'hA: seg_n_d = 7'h08;
      4'hB: seg_n_d = 7'h03;
      4'hC: seg_n_d = 7'h46;
      4'hD: seg_n_d = 7'h21;
      4'hE: seg_n_d = 7'h06;
      4'hF: seg_n_d = 7'h0E;
      default: seg_n_d = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
      an_n_q   <= 4'hF;
      seg_n_q  <= 7'h7F;
      dp_n_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      fd_q     <= fd_d;
      an_n_q   <= an_n_d;
      seg_n_q  <= seg_n_d;
      dp_n_q   <= dp_n_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed vector table plus hand-written multi-cycle sequences for display_scan_ctrl (DIV=8, BLANK=2).
module tb_display_scan_ctrl;
  localparam int DIV = 8, BLANK = 2;
  logic clk = 0, reset = 0, en = 1, load = 0;
  logic [15:0] value = '0;
  logic [3:0] dp_en = '0, digit_en = 4'hF;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic dp_n, busy, frame_done;
  int n_run = 0, n_fail = 0;

  display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .en(en), .value(value), .load(load), .dp_en(dp_en),
    .digit_en(digit_en), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  de;
    logic [3:0]  dp;
    logic [27:0] seg;
    logic [15:0] an;
    logic [3:0]  dpn;
  } vec_t;
  vec_t tv [6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int k = 0;
    step();
    while (!frame_done && k < 100) begin
      step();
      k++;
    end
    chk("frame_reached", {15'd0, frame_done}, 16'd1);
  endtask

  initial begin
    tv[0] = '{16'h0000, 4'hF, 4'h0, {7'h40, 7'h40, 7'h40, 7'h40}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF};
    tv[1] = '{16'hF8A1, 4'hF, 4'h0, {7'h0E, 7'h00, 7'h08, 7'h79}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'hF};
    tv[2] = '{16'h3210, 4'b0101, 4'b0001, {7'h30, 7'h24, 7'h79, 7'h40}, {4'b1111, 4'b1011, 4'b1111, 4'b1110}, 4'b1110};
    tv[3] = '{16'h7654, 4'hF, 4'b1010, {7'h78, 7'h02, 7'h12, 7'h19}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b0101};
    tv[4] = '{16'hEDCB, 4'b1010, 4'hF, {7'h06, 7'h21, 7'h46, 7'h03}, {4'b0111, 4'b1111, 4'b1101, 4'b1111}, 4'b0101};
    tv[5] = '{16'h9999, 4'h0, 4'hF, {7'h10, 7'h10, 7'h10, 7'h10}, 16'hFFFF, 4'hF};

    #1 reset = 1;
    #1;
    chk("rst_an", {12'd0, an_n}, 16'hF);
    chk("rst_seg", {9'd0, seg_n}, 16'h7F);
    chk("rst_dp", {15'd0, dp_n}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_fd", {15'd0, frame_done}, 16'd0);
    step(2);
    #3 reset = 0;
    step(2);
    chk("first_blank", {12'd0, an_n}, 16'hF);
    step();
    chk("first_drive", {12'd0, an_n}, 16'hE);

    begin
      int c = 0;
      wait_frame();
      do begin
        step();
        c++;
      end while (!frame_done && c < 100);
      chk("frame_period", 16'(c), 16'd32);
    end

    for (int i = 0; i < 6; i++) begin
      digit_en = tv[i].de;
      dp_en = tv[i].dp;
      wait_frame();
      step(5);
      value = tv[i].value;
      load = 1;
      step();
      load = 0;
      chk($sformatf("v%0d_busy_set", i), {15'd0, busy}, 16'd1);
      wait_frame();
      chk($sformatf("v%0d_busy_clr", i), {15'd0, busy}, 16'd0);
      for (int d = 0; d < 4; d++) begin
        step(2);
        chk($sformatf("v%0d_d%0d_blank", i, d), {12'd0, an_n}, 16'hF);
        step(2);
        chk($sformatf("v%0d_d%0d_an", i, d), {12'd0, an_n}, {12'd0, tv[i].an[4*d +: 4]});
        chk($sformatf("v%0d_d%0d_seg", i, d), {9'd0, seg_n}, {9'd0, tv[i].seg[7*d +: 7]});
        chk($sformatf("v%0d_d%0d_dp", i, d), {15'd0, dp_n}, {15'd0, tv[i].dpn[d]});
        step(4);
      end
    end

    digit_en = 4'hF;
    dp_en = 4'h0;
    wait_frame();
    step(3);
    value = 16'h1111;
    load = 1;
    step();
    value = 16'h2222;
    step();
    load = 0;
    wait_frame();
    chk("dbl_busy", {15'd0, busy}, 16'd0);
    step(4);
    chk("dbl_seg", {9'd0, seg_n}, 16'h24);

    wait_frame();
    step(2);
    value = 16'h5555;
    load = 1;
    step();
    load = 0;
    chk("bnd_busy_set", {15'd0, busy}, 16'd1);
    step(28);
    value = 16'h6666;
    load = 1;
    step();
    load = 0;
    chk("bnd_fd", {15'd0, frame_done}, 16'd1);
    chk("bnd_busy", {15'd0, busy}, 16'd0);
    step(4);
    chk("bnd_seg", {9'd0, seg_n}, 16'h02);

    wait_frame();
    step(20);
    en = 0;
    step();
    chk("frz_an0", {12'd0, an_n}, 16'hF);
    chk("frz_dp0", {15'd0, dp_n}, 16'd1);
    step(19);
    chk("frz_an1", {12'd0, an_n}, 16'hF);
    en = 1;
    step();
    chk("res_an2", {12'd0, an_n}, 16'hB);
    step(3);
    chk("res_an2_end", {12'd0, an_n}, 16'hB);
    step(3);
    chk("res_an3", {12'd0, an_n}, 16'h7);
    step(4);
    chk("res_fd_early", {15'd0, frame_done}, 16'd0);
    step();
    chk("res_fd", {15'd0, frame_done}, 16'd1);

    step();
    value = 16'hABCD;
    load = 1;
    step();
    load = 0;
    chk("rb_busy_set", {15'd0, busy}, 16'd1);
    #2 reset = 1;
    #1;
    chk("rb_an", {12'd0, an_n}, 16'hF);
    chk("rb_seg", {9'd0, seg_n}, 16'h7F);
    chk("rb_dp", {15'd0, dp_n}, 16'd1);
    chk("rb_busy", {15'd0, busy}, 16'd0);
    chk("rb_fd", {15'd0, frame_done}, 16'd0);
    step(2);
    #3 reset = 0;
    wait_frame();
    chk("rb_busy_after", {15'd0, busy}, 16'd0);
    step(4);
    chk("rb_seg_after", {9'd0, seg_n}, 16'h40);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000, clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK, default 16, leading cycles of each slot with all anodes off; legal range 0..DIV-1.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  scan enable; low freezes scanning and blanks the display.
REQ-006 value  input  16  four hex nibbles; digit k shows value[4k+3:4k].
REQ-007 load  input  1  one-cycle strobe; requests display of value.
REQ-008 dp_en  input  4  decimal point per digit, active-high.
REQ-009 digit_en  input  4  per-digit enable mask; 0 keeps that digit dark.
REQ-010 an_n  output  4  digit anode select, active-low, at most one bit low.
REQ-011 seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp_n  output  1  decimal point, active-low.
REQ-013 busy  output  1  high while a loaded value awaits its frame boundary.
REQ-014 frame_done  output  1  one-cycle pulse when digit 3 slot ends.

Function
REQ-015 Prescaler cnt counts 0..DIV-1 while en=1 and wraps to 0; wrap cycle = slot end.
REQ-016 2-bit digit index idx increments at each slot end, 3 wraps to 0 (frame boundary).
REQ-017 Anode pattern for idx 0/1/2/3 SHALL be 1110/1101/1011/0111, matching the team's 2-to-4 active-low digit decoder.
REQ-018 During cnt < BLANK, or when digit_en[idx]=0, an_n SHALL be 1111.
REQ-019 seg_n SHALL be hex decode of shadow nibble idx: 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110; remaining digits standard hex glyphs.
REQ-020 dp_n SHALL be ~dp_en[idx] when the anode is active, else 1.
REQ-021 an_n, seg_n, dp_n are registered: reflect (cnt, idx) of the previous cycle, latency 1.
REQ-022 load=1 SHALL capture value into pending register and set busy next cycle; a later load before the boundary overwrites pending.
REQ-023 At frame boundary with busy=1 and load=0, shadow <= pending, busy <= 0.
REQ-024 At frame boundary with load=1, shadow <= value directly, busy <= 0 (simultaneous load wins).
REQ-025 Shadow SHALL never change except at a frame boundary (no tearing within a frame).
REQ-026 frame_done SHALL pulse for exactly the cycle after the idx 3->0 wrap.
REQ-027 en=0: cnt and idx hold, load still captured to pending, boundary transfers suspended, an_n=1111 and dp_n=1 from next cycle.
REQ-028 en returning to 1 SHALL resume from held cnt/idx with no skipped or repeated slot.

Reset
REQ-029 Reset asserted SHALL immediately force cnt=0, idx=0, pending=0, shadow=0, busy=0, frame_done=0, an_n=1111, seg_n=1111111, dp_n=1.
REQ-030 Reset mid-frame SHALL discard pending load; after release, scanning restarts at idx 0, cnt 0.
REQ-031 First rising edge after reset release with en=1 SHALL start counting; first anode drive occurs at cnt=BLANK (latency 1).

Verification (DIV=8, BLANK=2)
REQ-032 Reset, en=1, no load -> an_n cycles 1110,1101,1011,0111 each low 6 of 8 cycles, seg_n=1000000 throughout; frame_done every 32 cycles.
REQ-033 load value=16'hF8A1 mid-frame -> busy=1 until boundary; next frame digits 0..3 show 1111001,0001000,0000000,0001110.
REQ-034 Two loads (16'h1111 then 16'h2222) in one frame -> only 16'h2222 displayed; load on exact boundary cycle -> that value shown in the frame starting at that boundary, busy=0.
REQ-035 digit_en=4'b0101, dp_en=4'b0001 -> an_n never 1101 or 0111; dp_n=0 only while an_n=1110.
REQ-036 en low for 20 cycles during idx 2 -> an_n=1111, cnt/idx frozen; after re-enable idx 2 completes remaining cycles, then idx 3.
REQ-037 Reset pulse during busy=1 -> all outputs at reset values asynchronously, shadow=0, busy=0 after release.
